// File: rtl/sfifo_param.sv
// ============================================================================
// Module   : sfifo_param
// Purpose  : Parametrised single-clock FIFO with fill level, thresholds,
//            read-valid strobe, flush and overflow/underflow reporting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sfifo_param #(
    parameter int DW        = 16,
    parameter int AW        = 6,
    parameter int AF_THRESH = 60,
    parameter int AE_THRESH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          err_clr,
    input  logic          wr,
    input  logic [DW-1:0] din,
    output logic          full,
    output logic          almost_full,
    output logic          ovfl,
    output logic          ovfl_sticky,
    input  logic          rd,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    output logic          empty,
    output logic          almost_empty,
    output logic          udfl,
    output logic          udfl_sticky,
    output logic [AW:0]   level
);

    localparam int DEPTH = 2 ** AW;
    // One extra bit so out-of-range thresholds compare without truncation aliasing.
    localparam logic [AW+1:0] C_DEPTH = DEPTH[AW+1:0];
    localparam logic [AW+1:0] C_AF    = AF_THRESH[AW+1:0];
    localparam logic [AW+1:0] C_AE    = AE_THRESH[AW+1:0];

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_acc;
    logic          rd_acc;
    logic          ovfl_cond;
    logic          udfl_cond;

    always_comb begin
        full         = ({1'b0, level} == C_DEPTH);
        empty        = (level == '0);
        almost_full  = ({1'b0, level} >= C_AF);
        almost_empty = ({1'b0, level} <= C_AE);
        wr_acc       = wr & ~full & ~flush;
        rd_acc       = rd & ~empty & ~flush;
        ovfl_cond    = wr & full & ~flush;
        udfl_cond    = rd & empty & ~flush;
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            dout     <= '0;
            dout_vld <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            dout_vld <= 1'b0;
        end else begin
            dout_vld <= rd_acc;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // A new error in the same cycle as err_clr keeps the sticky flag set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovfl        <= 1'b0;
            udfl        <= 1'b0;
            ovfl_sticky <= 1'b0;
            udfl_sticky <= 1'b0;
        end else begin
            ovfl <= ovfl_cond;
            udfl <= udfl_cond;
            if (ovfl_cond) begin
                ovfl_sticky <= 1'b1;
            end else if (err_clr) begin
                ovfl_sticky <= 1'b0;
            end
            if (udfl_cond) begin
                udfl_sticky <= 1'b1;
            end else if (err_clr) begin
                udfl_sticky <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
